// File: rtl/core_bus_port_if.sv
// Bundles the core command/response handshake and the arbiter bus lines of core_bus_port.
// master: the port itself; slave: the core plus arbiter side that drives it.
interface core_bus_port_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          wr_done;
  logic          bus_request;
  logic          bus_rw;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_data_out;
  logic [DW-1:0] bus_data_in;
  logic          bus_grant;

  modport master (
    input  cmd_valid, cmd_rw, cmd_address, cmd_wdata, rsp_ready, bus_data_in, bus_grant,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, wr_done,
           bus_request, bus_rw, bus_address, bus_data_out
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_address, cmd_wdata, rsp_ready, bus_data_in, bus_grant,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, wr_done,
           bus_request, bus_rw, bus_address, bus_data_out
  );
endinterface

// File: rtl/core_bus_port.sv
// Core-side bus initiator: command FIFO, request/grant FSM with a GAP cycle, and a read response register.
// Optional grant-wait timeout is enabled by defining CORE_BUS_PORT_TIMEOUT_EN.
module core_bus_port #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset,
  core_bus_port_if.master bif
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + AW + DW;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("core_bus_port: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          bus_request_q, bus_request_d;
  logic          bus_rw_q, bus_rw_d;
  logic [AW-1:0] bus_address_q, bus_address_d;
  logic [DW-1:0] bus_data_q, bus_data_d;
  logic          wr_done_q, wr_done_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          push, pop, empty, done, abort;
  logic [EW-1:0] head;

`ifdef CORE_BUS_PORT_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  assign push  = bif.cmd_valid && cmd_ready_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

  // cmd_ready is registered from the post-update occupancy, so a full FIFO never accepts.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    if (push) mem_d[wr_ptr_q[PW-1:0]] = {bif.cmd_rw, bif.cmd_address, bif.cmd_wdata};
    cmd_ready_d = !((wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                    (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]));
  end

  always_comb begin
    state_d       = state_q;
    bus_request_d = bus_request_q;
    bus_rw_d      = bus_rw_q;
    bus_address_d = bus_address_q;
    bus_data_d    = bus_data_q;
    wr_done_d     = 1'b0;
    rsp_valid_d   = rsp_valid_q && !bif.rsp_ready;
    rsp_rdata_d   = rsp_rdata_q;
    pop           = 1'b0;
    done          = 1'b0;
    abort         = 1'b0;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_err_d     = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty && (!head[EW-1] || !rsp_valid_q)) begin
          bus_rw_d      = head[EW-1];
          bus_address_d = head[DW +: AW];
          bus_data_d    = head[DW-1:0];
          bus_request_d = 1'b1;
          state_d       = REQ;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      REQ: begin
        done = bif.bus_grant;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
        abort = !bif.bus_grant && (cnt_q == CNT_LAST);
        cnt_d = cnt_q + 1'b1;
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A grant and a timeout expiry share the completion path; a grant always takes priority.
    if (done || abort) begin
      pop           = 1'b1;
      bus_request_d = 1'b0;
      state_d       = GAP;
      if (bus_rw_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = abort ? '1 : bif.bus_data_in;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
        rsp_err_d   = abort;
`endif
      end else begin
        wr_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_ready_q   <= 1'b1;
      bus_request_q <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_address_q <= '0;
      bus_data_q    <= '0;
      wr_done_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmd_ready_q   <= cmd_ready_d;
      bus_request_q <= bus_request_d;
      bus_rw_q      <= bus_rw_d;
      bus_address_q <= bus_address_d;
      bus_data_q    <= bus_data_d;
      wr_done_q     <= wr_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_err_q     <= rsp_err_d;
`endif
    end
  end

  assign bif.cmd_ready    = cmd_ready_q;
  assign bif.bus_request  = bus_request_q;
  assign bif.bus_rw       = bus_rw_q;
  assign bif.bus_address  = bus_address_q;
  assign bif.bus_data_out = bus_data_q;
  assign bif.wr_done      = wr_done_q;
  assign bif.rsp_valid    = rsp_valid_q;
  assign bif.rsp_rdata    = rsp_rdata_q;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
  assign bif.rsp_err      = rsp_err_q;
`else
  assign bif.rsp_err      = 1'b0;
`endif
endmodule

// File: tb/tb_core_bus_port.sv
// Bench for core_bus_port: transaction-level model compared every cycle, plus directed literal checks.
module tb_core_bus_port;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int TOUT  = 10;
`ifdef CORE_BUS_PORT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  core_bus_port_if #(.AW(AW), .DW(DW)) bif ();

  core_bus_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bif  (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: queue of accepted commands, the one on the bus, and spacing rules.
  typedef struct {
    logic          rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          mcur;
  cmd_t          mnew;
  bit            m_req = 0, m_wr = 0, m_rv = 0, m_err = 0, m_rdy = 1;
  bit            m_rv0, m_push, m_fin, m_abort;
  logic [DW-1:0] m_rd = '0;
  int            m_gap = 0, m_wait = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_req = 0; m_wr = 0; m_rv = 0; m_err = 0; m_rdy = 1;
      m_rd = '0; m_gap = 0; m_wait = 0;
    end else begin
      m_rv0  = m_rv;
      m_push = bif.cmd_valid && m_rdy;
      mnew   = '{bif.cmd_rw, bif.cmd_address, bif.cmd_wdata};
      m_wr   = 0;
      if (m_rv && bif.rsp_ready) m_rv = 0;
      if (m_req) begin
        m_wait++;
        m_fin   = bif.bus_grant;
        m_abort = TO_EN && !bif.bus_grant && (m_wait >= TOUT);
        if (m_fin || m_abort) begin
          m_req = 0;
          void'(mq.pop_front());
          m_gap = 1;
          if (mcur.rw) begin
            m_rv  = 1;
            m_err = m_abort;
            m_rd  = m_abort ? 8'hFF : bif.bus_data_in;
          end else begin
            m_wr = 1;
          end
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (mq.size() > 0 && (!mq[0].rw || !m_rv0)) begin
        m_req  = 1;
        mcur   = mq[0];
        m_wait = 0;
      end
      if (m_push) mq.push_back(mnew);
      m_rdy = (mq.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", bif.cmd_ready, m_rdy);
    chk("bus_request", bif.bus_request, m_req);
    chk("wr_done", bif.wr_done, m_wr);
    chk("rsp_valid", bif.rsp_valid, m_rv);
    if (m_req) begin
      chk("bus_rw", bif.bus_rw, mcur.rw);
      chk("bus_address", bif.bus_address, mcur.a);
      chk("bus_data_out", bif.bus_data_out, mcur.d);
    end
    if (m_rv) begin
      chk("rsp_rdata", bif.rsp_rdata, m_rd);
      chk("rsp_err", bif.rsp_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bif.cmd_valid = 1'b1; bif.cmd_rw = rw; bif.cmd_address = a; bif.cmd_wdata = d;
    while (!bif.cmd_ready && n < 50) begin tick(); n++; end
    chk("push_accept", bif.cmd_ready, 1);
    tick();
    bif.cmd_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bif.bus_request && n < 100) begin tick(); n++; end
    chk("req_wait", bif.bus_request, 1);
  endtask

  task automatic do_grant(input logic [DW-1:0] din);
    bif.bus_grant = 1'b1; bif.bus_data_in = din;
    tick();
    bif.bus_grant = 1'b0; bif.bus_data_in = 8'hE7;
  endtask

  initial begin
    bif.cmd_valid = 0; bif.cmd_rw = 0; bif.cmd_address = '0; bif.cmd_wdata = '0;
    bif.rsp_ready = 0; bif.bus_grant = 0; bif.bus_data_in = '0;
    #1 reset = 1'b1;
    repeat (2) tick();
    chk("rst_cmd_ready", bif.cmd_ready, 1);
    chk("rst_bus_request", bif.bus_request, 0);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_wr_done", bif.wr_done, 0);
    chk("rst_rsp_rdata", bif.rsp_rdata, 0);
    chk("rst_bus_address", bif.bus_address, 0);
    chk("rst_rsp_err", bif.rsp_err, 0);
    reset = 1'b0;
    tick();

    // Single write, grant 4 cycles after request
    push(1'b0, 9'h1A5, 8'h3C);
    chk("wr_lat_c1", bif.bus_request, 0);
    tick();
    chk("wr_lat_c2", bif.bus_request, 1);
    chk("wr_addr", bif.bus_address, 9'h1A5);
    chk("wr_data", bif.bus_data_out, 8'h3C);
    chk("wr_rw", bif.bus_rw, 0);
    repeat (4) begin
      tick();
      chk("wr_hold_addr", bif.bus_address, 9'h1A5);
      chk("wr_hold_req", bif.bus_request, 1);
    end
    do_grant(8'h00);
    chk("wr_done_pulse", bif.wr_done, 1);
    chk("wr_req_drop", bif.bus_request, 0);
    tick();
    chk("wr_done_once", bif.wr_done, 0);

    // Single read held unconsumed for 5 cycles
    push(1'b1, 9'h002, 8'h00);
    wait_req();
    chk("rd_rw", bif.bus_rw, 1);
    do_grant(8'h9E);
    repeat (5) begin
      chk("rd_valid_hold", bif.rsp_valid, 1);
      chk("rd_data_hold", bif.rsp_rdata, 8'h9E);
      tick();
    end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    chk("rd_valid_clear", bif.rsp_valid, 0);

    // FIFO full: third push stalls until the first grant, order preserved
    push(1'b0, 9'h010, 8'h11);
    push(1'b0, 9'h020, 8'h22);
    chk("full_ready", bif.cmd_ready, 0);
    bif.cmd_valid = 1'b1; bif.cmd_rw = 1'b0; bif.cmd_address = 9'h030; bif.cmd_wdata = 8'h33;
    repeat (3) begin
      tick();
      chk("full_stall", bif.cmd_ready, 0);
    end
    chk("full_head", bif.bus_address, 9'h010);
    do_grant(8'h00);
    chk("full_ready_back", bif.cmd_ready, 1);
    tick();
    bif.cmd_valid = 1'b0;
    wait_req();
    chk("order_b", bif.bus_address, 9'h020);
    do_grant(8'h00);
    wait_req();
    chk("order_c", bif.bus_address, 9'h030);
    chk("order_c_data", bif.bus_data_out, 8'h33);
    do_grant(8'h00);
    tick();

    // Second read waits until the first response is consumed
    push(1'b1, 9'h044, 8'h00);
    push(1'b1, 9'h055, 8'h00);
    wait_req();
    chk("blk_first", bif.bus_address, 9'h044);
    do_grant(8'h5A);
    repeat (6) begin
      tick();
      chk("blk_no_req", bif.bus_request, 0);
    end
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    wait_req();
    chk("blk_second", bif.bus_address, 9'h055);
    do_grant(8'hA5);
    chk("blk_rdata", bif.rsp_rdata, 8'hA5);
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;

    // Asynchronous reset while a read waits for grant
    push(1'b1, 9'h0AB, 8'h00);
    push(1'b0, 9'h0CD, 8'h77);
    wait_req();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_req", bif.bus_request, 0);
    chk("arst_rsp_valid", bif.rsp_valid, 0);
    chk("arst_ready", bif.cmd_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    do_grant(8'h12);
    repeat (4) tick();
    chk("stray_req", bif.bus_request, 0);
    chk("stray_wr_done", bif.wr_done, 0);
    chk("stray_rsp", bif.rsp_valid, 0);

`ifdef CORE_BUS_PORT_TIMEOUT_EN
    // Timeout abort, then a grant landing exactly on the expiry cycle
    push(1'b1, 9'h0C3, 8'h00);
    wait_req();
    repeat (TOUT) tick();
    chk("to_valid", bif.rsp_valid, 1);
    chk("to_err", bif.rsp_err, 1);
    chk("to_rdata", bif.rsp_rdata, 8'hFF);
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
    push(1'b1, 9'h0C4, 8'h00);
    wait_req();
    repeat (TOUT - 1) tick();
    do_grant(8'h66);
    chk("to_race_valid", bif.rsp_valid, 1);
    chk("to_race_err", bif.rsp_err, 0);
    chk("to_race_rdata", bif.rsp_rdata, 8'h66);
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
